// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: bundles the loader port, CPU port, RAM32 macro side and
// status of the SRAM arbiter. The arbiter connects through the slave modport;
// requesters, the RAM model and the testbench use the master modport.
interface sram_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  // Loader port
  logic              ldr_req;
  logic              ldr_we;
  logic [AW-1:0]     ldr_addr;
  logic [DW-1:0]     ldr_wdata;
  logic              ldr_lock;
  logic              ldr_ack;
  logic [DW-1:0]     ldr_rdata;
  // CPU port
  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [DW-1:0]     cpu_wdata;
  logic [DW/8-1:0]   cpu_wmask;
  logic              cpu_ack;
  logic [DW-1:0]     cpu_rdata;
  // RAM macro side
  logic              ram_en;
  logic [AW-1:0]     ram_addr;
  logic [DW/8-1:0]   ram_we;
  logic [DW-1:0]     ram_wdata;
  logic [DW-1:0]     ram_rdata;
  // Status
  logic              busy;

  modport slave (
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
    output ldr_ack, ldr_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask,
    output cpu_ack, cpu_rdata,
    output ram_en, ram_addr, ram_we, ram_wdata,
    input  ram_rdata,
    output busy
  );

  modport master (
    output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
    input  ldr_ack, ldr_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask,
    input  cpu_ack, cpu_rdata,
    input  ram_en, ram_addr, ram_we, ram_wdata,
    output ram_rdata,
    input  busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the single-port RAM32 macro between the UART loader and
// the serv core. One access at a time: grant in IDLE, one enable cycle in
// ACCESS, ack plus read data in RESP. ldr_lock keeps the CPU off the RAM.
// Optional macro SRAM_ARB_ROUND_ROBIN_EN: alternate grants on contention
// instead of fixed loader priority.
module sram_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  sram_arbiter_if.slave bus
);
  localparam int MW = DW / 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [MW-1:0] wmask_q, wmask_d;

  logic          ldrElig;
  logic          cpuElig;
  logic          grantLdr;
  logic          grantCpu;
  logic [AW-1:0] cpuWordAddr;
  logic          unusedAddrBits;

  assign cpuWordAddr    = bus.cpu_addr[AW+1:2];
  assign unusedAddrBits = ^{bus.cpu_addr[31:AW+2], bus.cpu_addr[1:0]};
  assign ldrElig        = bus.ldr_req;
  assign cpuElig        = bus.cpu_req & ~bus.ldr_lock;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  // On contention the port not granted last time wins; remember each grant
  always_comb begin
    grantLdr     = ldrElig & (~cpuElig | last_grant_q);
    grantCpu     = cpuElig & (~ldrElig | ~last_grant_q);
    last_grant_d = last_grant_q;
    if (state_q == IDLE) begin
      if (grantLdr) begin
        last_grant_d = 1'b0;
      end else if (grantCpu) begin
        last_grant_d = 1'b1;
      end
    end
  end

  // Last-grant history register (0 = loader, 1 = CPU)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  // Fixed priority: the loader always wins on contention
  always_comb begin
    grantLdr = ldrElig;
    grantCpu = cpuElig & ~ldrElig;
  end
`endif

  // Sequencer: capture the winning command in IDLE, then one ACCESS and one RESP cycle
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    case (state_q)
      IDLE: begin
        if (grantLdr) begin
          owner_d = 1'b0;
          addr_d  = bus.ldr_addr;
          wdata_d = bus.ldr_wdata;
          wmask_d = bus.ldr_we ? {MW{1'b1}} : {MW{1'b0}};
          state_d = ACCESS;
        end else if (grantCpu) begin
          owner_d = 1'b1;
          addr_d  = cpuWordAddr;
          wdata_d = bus.cpu_wdata;
          wmask_d = bus.cpu_we ? bus.cpu_wmask : {MW{1'b0}};
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered command; reset aborts any transaction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  // Outputs decode straight from state so reset drops enable and acks at once
  always_comb begin
    bus.ram_en    = (state_q == ACCESS);
    bus.ram_addr  = addr_q;
    bus.ram_wdata = wdata_q;
    bus.ram_we    = (state_q == ACCESS) ? wmask_q : {MW{1'b0}};
    bus.ldr_ack   = (state_q == RESP) & ~owner_q;
    bus.cpu_ack   = (state_q == RESP) & owner_q;
    bus.ldr_rdata = bus.ldr_ack ? bus.ram_rdata : {DW{1'b0}};
    bus.cpu_rdata = bus.cpu_ack ? bus.ram_rdata : {DW{1'b0}};
    bus.busy      = (state_q != IDLE);
  end
endmodule
